// File: rtl/wb_debug_initiator.sv
// Wishbone classic single-transfer initiator: accepts one read/write command,
// runs one bus cycle with an ack timeout, and returns data or an error response.
module wb_debug_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [31:0]          cmd_adr_i,
    input  logic [31:0]          cmd_dat_i,
    input  logic [3:0]           cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [31:0]          wbm_dat_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o,
    output logic [CNT_WIDTH-1:0] tmo_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_dat_q;
    logic                   rsp_err_q;
    logic                   cyc_q;
    logic                   stb_q;
    logic                   we_q;
    logic [3:0]             sel_q;
    logic [31:0]            adr_q;
    logic [31:0]            dat_q;
    logic [15:0]            wait_q;
    logic [CNT_WIDTH-1:0]   xfer_cnt_q;
    logic [CNT_WIDTH-1:0]   tmo_cnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            wait_q      <= 16'h0;
            xfer_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        we_q        <= cmd_we_i;
                        sel_q       <= cmd_sel_i;
                        dat_q       <= cmd_dat_i;
                        adr_q       <= {cmd_adr_i[31:2], 2'b00};
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        wait_q      <= 16'h0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack is checked first so an ack on the last allowed edge wins.
                    if (wbm_ack_i) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_dat_q   <= we_q ? 32'h0 : wbm_dat_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        xfer_cnt_q  <= xfer_cnt_q + CNT_WIDTH'(1);
                        state_q     <= ST_RESP;
                    end else if (wait_q == TMO_LAST) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_dat_q   <= 32'hFFFF_FFFF;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        tmo_cnt_q   <= tmo_cnt_q + CNT_WIDTH'(1);
                        state_q     <= ST_RESP;
                    end else begin
                        wait_q <= wait_q + 16'h1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    cyc_q       <= 1'b0;
                    stb_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign xfer_cnt_o  = xfer_cnt_q;
    assign tmo_cnt_o   = tmo_cnt_q;

endmodule

// File: tb/tb_wb_debug_initiator.sv
// Directed bench for wb_debug_initiator with an 8-cycle timeout and 4-bit counters.
module tb_wb_debug_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    logic        busy;
    logic [3:0]  xfer_cnt, tmo_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [3:0]  exp_xfer = 4'd0;
    logic [3:0]  exp_tmo  = 4'd0;

    always #5 clk = ~clk;

    wb_debug_initiator #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat),
        .busy_o(busy), .xfer_cnt_o(xfer_cnt), .tmo_cnt_o(tmo_cnt)
    );

    // Called at posedge+1 in IDLE; returns at posedge+1 of the first BUS cycle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Acts as responder; ack_at=0 means never ack. Counts cycles with cyc high.
    task automatic bus_phase(input int ack_at, input logic [31:0] rd, output int ncyc);
        ncyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (cyc !== 1'b1) break;
            ncyc++;
            ack  = (k == ack_at);
            rdat = (k == ack_at) ? rd : 32'h0;
            @(posedge clk); #1;
        end
        ack = 1'b0; rdat = 32'h0;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
        rsp_ready = 0; ack = 0; rdat = 0;
        #12;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
        n_checks++; if ({cyc, stb, rsp_valid, busy} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {cyc, stb, rsp_valid, busy}); else n_pass++;
        n_checks++; if ({xfer_cnt, tmo_cnt} !== 8'h00) $display("FAIL reset_cnt: got %h expected 00", {xfer_cnt, tmo_cnt}); else n_pass++;
        n_checks++; if (rsp_dat !== 32'h0) $display("FAIL reset_rsp_dat: got %h expected 0", rsp_dat); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset done");
    endtask

    task automatic test_write();
        int n;
        issue(1'b1, 32'h300F_FFF8, 32'hA5A5_1234, 4'hF);
        n_checks++; if (wdat !== 32'hA5A5_1234) $display("FAIL wr_dat: got %h expected A5A51234", wdat); else n_pass++;
        n_checks++; if ({we, sel, adr} !== {1'b1, 4'hF, 32'h300F_FFF8}) $display("FAIL wr_bus: got %b %h %h expected 1 f 300ffff8", we, sel, adr); else n_pass++;
        n_checks++; if ({cmd_ready, busy, stb} !== 3'b011) $display("FAIL wr_state: got %b expected 011", {cmd_ready, busy, stb}); else n_pass++;
        bus_phase(3, 32'h1111_2222, n);
        exp_xfer = exp_xfer + 4'd1;
        n_checks++; if (n != 3) $display("FAIL wr_cyc_len: got %0d expected 3", n); else n_pass++;
        n_checks++; if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'h0}) $display("FAIL wr_rsp: got %b %b %h expected 1 0 0", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        chk("wr_xfer_cnt", 32'(xfer_cnt), 32'(exp_xfer));
        accept_rsp();
        n_checks++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) $display("FAIL wr_after_rsp: got %b expected 100", {cmd_ready, rsp_valid, busy}); else n_pass++;
        $display("write: cyc=%0d xfer=%0d", n, xfer_cnt);
    endtask

    task automatic test_read();
        int n;
        issue(1'b0, 32'h300F_FFFE, 32'h0, 4'hF);
        n_checks++; if ({we, adr} !== {1'b0, 32'h300F_FFFC}) $display("FAIL rd_adr: got %b %h expected 0 300ffffc", we, adr); else n_pass++;
        bus_phase(1, 32'hDEAD_0001, n);
        exp_xfer = exp_xfer + 4'd1;
        n_checks++; if (n != 1) $display("FAIL rd_cyc_len: got %0d expected 1", n); else n_pass++;
        n_checks++; if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'hDEAD_0001}) $display("FAIL rd_rsp: got %b %b %h expected 1 0 dead0001", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        chk("rd_xfer_cnt", 32'(xfer_cnt), 32'(exp_xfer));
        accept_rsp();
        $display("read: cyc=%0d dat=%h", n, rsp_dat);
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        bus_phase(0, 32'h0, n);
        exp_tmo = exp_tmo + 4'd1;
        n_checks++; if (n != 8) $display("FAIL tmo_cyc_len: got %0d expected 8", n); else n_pass++;
        n_checks++; if ({rsp_valid, rsp_err, rsp_dat} !== {2'b11, 32'hFFFF_FFFF}) $display("FAIL tmo_rsp: got %b %b %h expected 1 1 ffffffff", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        chk("tmo_tmo_cnt", 32'(tmo_cnt), 32'(exp_tmo));
        chk("tmo_xfer_cnt", 32'(xfer_cnt), 32'(exp_xfer));
        accept_rsp();
        $display("timeout: cyc=%0d tmo=%0d", n, tmo_cnt);
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        bus_phase(8, 32'h1234_5678, n);
        exp_xfer = exp_xfer + 4'd1;
        n_checks++; if (n != 8) $display("FAIL late_ack_cyc_len: got %0d expected 8", n); else n_pass++;
        n_checks++; if ({rsp_err, rsp_dat} !== {1'b0, 32'h1234_5678}) $display("FAIL late_ack_rsp: got %b %h expected 0 12345678", rsp_err, rsp_dat); else n_pass++;
        chk("late_ack_xfer_cnt", 32'(xfer_cnt), 32'(exp_xfer));
        chk("late_ack_tmo_cnt", 32'(tmo_cnt), 32'(exp_tmo));
        accept_rsp();
        $display("late ack: cyc=%0d xfer=%0d", n, xfer_cnt);
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        bus_phase(2, 32'hCAFE_F00D, n);
        exp_xfer = exp_xfer + 4'd1;
        cmd_we = 1'b1; cmd_adr = 32'h3000_0044; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'hC;
        cmd_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            ack = (c == 2);
            @(posedge clk); #1;
            ack = 1'b0;
            if ({rsp_valid, rsp_err, rsp_dat} !== {2'b10, 32'hCAFE_F00D}) bad++;
            if ({cmd_ready, cyc, stb} !== 3'b000) bad++;
            if ({xfer_cnt, tmo_cnt} !== {exp_xfer, exp_tmo}) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL bp_hold: got %0d deviations expected 0", bad); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++; if ({cmd_ready, rsp_valid, cyc} !== 3'b100) $display("FAIL bp_release: got %b expected 100", {cmd_ready, rsp_valid, cyc}); else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++; if ({cyc, we, sel, adr} !== {2'b11, 4'hC, 32'h3000_0044}) $display("FAIL bp_next_cmd: got %b %b %h %h expected 1 1 c 30000044", cyc, we, sel, adr); else n_pass++;
        bus_phase(1, 32'h0, n);
        exp_xfer = exp_xfer + 4'd1;
        chk("bp_xfer_cnt", 32'(xfer_cnt), 32'(exp_xfer));
        accept_rsp();
        $display("backpressure: xfer=%0d", xfer_cnt);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 32'h3000_0030, 32'h0BAD_0BAD, 4'hF);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({cyc, stb, rsp_valid, busy} !== 4'b0000) $display("FAIL rst_mid_ctrl: got %b expected 0000", {cyc, stb, rsp_valid, busy}); else n_pass++;
        n_checks++; if ({xfer_cnt, tmo_cnt} !== 8'h00) $display("FAIL rst_mid_cnt: got %h expected 00", {xfer_cnt, tmo_cnt}); else n_pass++;
        exp_xfer = 4'd0; exp_tmo = 4'd0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({cmd_ready, cyc} !== 2'b10) $display("FAIL rst_mid_release: got %b expected 10", {cmd_ready, cyc}); else n_pass++;
        $display("reset mid-transfer done");
    endtask

    task automatic test_wrap();
        int n;
        for (int t = 1; t <= 17; t++) begin
            issue(t[0], 32'h3000_0100 + 32'(t * 4), 32'(t), 4'hF);
            bus_phase(1, 32'(t), n);
            accept_rsp();
            if (t == 16) chk("wrap_16", 32'(xfer_cnt), 32'd0);
        end
        chk("wrap_17", 32'(xfer_cnt), 32'd1);
        chk("wrap_tmo", 32'(tmo_cnt), 32'd0);
        $display("wrap: xfer=%0d", xfer_cnt);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_debug_initiator.md
Name: wb_debug_initiator

Overview:
- Wishbone classic single-transfer initiator: the master end of the user-area Wishbone slave interface.
- Accepts read/write commands on a valid/ready port, drives one bus cycle at a time, and returns read data or a timeout error on a valid/ready response port.
- Used in block-level benches and on-chip self-test to exercise the user-area responders, including the debug register pair at 0x300F_FFF8 / 0x300F_FFFC.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles wbm_cyc_o stays high awaiting ack; legal range 1..65535.
- CNT_WIDTH, 16, width of the completed-transfer and timeout counters.

Ports:
- wb_clk_i  input  1  system clock; all logic on the rising edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  block can accept a command.
- cmd_we_i  input  1  1 = write, 0 = read.
- cmd_adr_i  input  32  byte address.
- cmd_dat_i  input  32  write data.
- cmd_sel_i  input  4  byte lane select.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer accepts response.
- rsp_dat_o  output  32  read data; 0 for writes; 0xFFFF_FFFF on timeout.
- rsp_err_o  output  1  1 = transfer timed out.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte select.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- wbm_dat_i  input  32  Wishbone read data.
- busy_o  output  1  high whenever the FSM is not IDLE.
- xfer_cnt_o  output  CNT_WIDTH  count of transfers completed with ack.
- tmo_cnt_o  output  CNT_WIDTH  count of timed-out transfers.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - FSM goes to IDLE.
  - All outputs go to 0 except cmd_ready_o, which goes to 1.
  - Counters clear.
  - An in-flight Wishbone cycle is abandoned: cyc and stb drop without waiting for ack.
- All Wishbone outputs are registered; there is no combinational path from wbm_ack_i to any output.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - A command is accepted when cmd_valid_i and cmd_ready_o are both high at edge N.
  - At edge N: load we, sel, dat, and adr with adr[1:0] forced to 00; assert wbm_cyc_o and wbm_stb_o; clear the timeout counter; go to BUS.
  - Bus outputs are therefore visible in the cycle after acceptance (latency 1).
- BUS:
  - cmd_ready_o = 0; cyc, stb and all bus outputs held stable.
  - If wbm_ack_i is high at an edge: deassert cyc/stb at that edge.
    - rsp_dat_o gets wbm_dat_i for a read, 0 for a write.
    - rsp_err_o = 0; rsp_valid_o = 1; xfer_cnt_o increments; go to RESP.
  - If there is no ack and the timeout counter equals TIMEOUT_CYCLES-1: deassert cyc/stb.
    - rsp_dat_o = 0xFFFF_FFFF; rsp_err_o = 1; rsp_valid_o = 1; tmo_cnt_o increments; go to RESP.
  - Otherwise the timeout counter increments.
  - As a result, cyc is high for at most TIMEOUT_CYCLES cycles.
  - Ack on the final allowed edge wins over timeout.
  - Minimum bus cycle: ack in the first BUS cycle gives cyc high for exactly 1 cycle.
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held stable until rsp_ready_i is sampled high.
  - On that edge: rsp_valid_o = 0; go to IDLE; cmd_ready_o = 1 in the next cycle.
  - There is no RESP-to-BUS bypass, so back-to-back commands have at least 1 idle bus cycle between them.
- wbm_ack_i in IDLE or RESP (stray or late ack) is ignored and changes no state or counter.
- Counters wrap modulo 2^CNT_WIDTH.
- cmd_* inputs are don't-care unless cmd_valid_i is high in IDLE.
- rsp_ready_i is don't-care outside RESP.

Test Plan:
- Write: cmd we=1, adr=0x300F_FFF8, dat=0xA5A5_1234, sel=0xF; responder acks on the 3rd BUS cycle.
  - Required: cyc/stb high for exactly 3 cycles, wbm_dat_o=0xA5A5_1234.
  - Required: rsp_valid with rsp_dat=0, err=0; xfer_cnt=1.
- Read: cmd we=0, adr=0x300F_FFFE; ack in the 1st BUS cycle with wbm_dat_i=0xDEAD_0001.
  - Required: wbm_adr_o=0x300F_FFFC; cyc high 1 cycle.
  - Required: rsp_dat=0xDEAD_0001, err=0.
- Timeout: TIMEOUT_CYCLES=8, no ack.
  - Required: cyc high exactly 8 cycles; rsp_err=1, rsp_dat=0xFFFF_FFFF; tmo_cnt=1, xfer_cnt unchanged.
  - Then ack on edge 8 in a rerun: required err=0, xfer_cnt increments.
- Backpressure: hold rsp_ready_i=0 for 5 cycles after the response, with cmd_valid_i held high and a stray ack pulse injected.
  - Required: rsp fields stable, cmd_ready_o=0, no new bus cycle, counters unchanged.
  - Required: new command accepted the cycle after the rsp_ready_i handshake.
- Reset mid-transfer: assert wb_rst_i 2 cycles into BUS, between clock edges.
  - Required: cyc, stb and rsp_valid drop immediately (before the next edge); counters 0; cmd_ready_o=1 after release.
- Wrap: CNT_WIDTH=4, 17 acked transfers.
  - Required: xfer_cnt_o=1.
